// File: rtl/shift_pkg.sv
// Shared types for the shift units: op encoding, engine FSM states and op decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package shift_pkg;

    localparam int SH_WIDTH = 8;

    typedef enum logic [2:0] {
        SH_LSR,
        SH_LSL,
        SH_ASR,
        SH_ROR,
        SH_ROL
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // Rotate dominates arithmetic. A left arithmetic shift is the same as a
    // logical left, so ar is only honoured for right shifts.
    function automatic shift_op_t decode_op(input logic lr, input logic ar, input logic rot);
        shift_op_t op;
        if (rot)
            op = lr ? SH_ROL : SH_ROR;
        else if (lr)
            op = SH_LSL;
        else if (ar)
            op = SH_ASR;
        else
            op = SH_LSR;
        return op;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Moves the operand one bit position according to op (logical/arith/rotate, left/right).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: d = operand in, op = shift_op_t operation, q = operand moved one position.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            SH_LSR:  q = {1'b0, d[WIDTH-1:1]};
            SH_LSL:  q = {d[WIDTH-2:0], 1'b0};
            SH_ASR:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            SH_ROR:  q = {d[0], d[WIDTH-1:1]};
            SH_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/seq_shift_engine.sv
// Multi-cycle shift/rotate engine: one operand per request, one bit position per clock
// (two per clock while >=2 remain when SEQ_SHIFT_ENGINE_FAST_EN is defined).
// Latency: accept -> out_valid = cnt+1 cycles (fast build: ceil(cnt/2)+1); result held until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + i, n, lr, ar, rot request side;
// out_valid/out_ready + o result side; busy high while an op is in SHIFT or DONE.
module seq_shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i,
    input  logic [CNT_W-1:0] n,
    input  logic             lr,
    input  logic             ar,
    input  logic             rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             busy
);

    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    shift_op_t        op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] iter;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] step1;
    logic             accept;

    // Logical/arith shifts saturate: after WIDTH steps the result no longer changes.
    assign iter = rot ? (n % W_CNT) : ((n > W_CNT) ? W_CNT : n);

    shift_step #(.WIDTH(WIDTH)) u_step1 (.d(data_q), .op(op_q), .q(step1));

`ifdef SEQ_SHIFT_ENGINE_FAST_EN
    logic [WIDTH-1:0] step2;
    shift_step #(.WIDTH(WIDTH)) u_step2 (.d(step1), .op(op_q), .q(step2));

    always_comb begin
        if (cnt_q >= CNT_W'(2)) begin
            data_nxt = step2;
            cnt_nxt  = cnt_q - CNT_W'(2);
        end else begin
            data_nxt = step1;
            cnt_nxt  = cnt_q - CNT_W'(1);
        end
    end
`else
    assign data_nxt = step1;
    assign cnt_nxt  = cnt_q - CNT_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (iter == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (cnt_nxt == '0)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand and op are captured on accept only, so inputs changing while the
    // engine is busy cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            op_q   <= SH_LSR;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= i;
            op_q   <= decode_op(lr, ar, rot);
            cnt_q  <= iter;
        end else if (state == S_SHIFT) begin
            data_q <= data_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    assign o = data_q;

endmodule
